// File: rtl/control_if.sv
// rtl/control_if.sv - quiz sequencer status/command bundle
interface control_if;
    logic       READY_IN;
    logic       QUE_IN;
    logic       QUE;
    logic       OK_IN;
    logic       WRONG_IN;
    logic [1:0] JUDG_IN;
    logic [1:0] HP_IN;
    logic       READY_OUT;
    logic [3:0] STATE;

    modport master (
        output READY_IN, QUE_IN, QUE, OK_IN, WRONG_IN, JUDG_IN, HP_IN,
        input  READY_OUT, STATE
    );

    modport slave (
        input  READY_IN, QUE_IN, QUE, OK_IN, WRONG_IN, JUDG_IN, HP_IN,
        output READY_OUT, STATE
    );
endinterface

// File: rtl/control.sv
// rtl/control.sv - factorization quiz game sequencer FSM
module control #(
    parameter int NUM_Q = 8,
    parameter int HOLD  = 4
) (
    input  logic     CLK,
    input  logic     RST,
    control_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_READY   = 4'd1,
        S_QGEN    = 4'd2,
        S_INPUT   = 4'd3,
        S_JUDGE   = 4'd4,
        S_CORRECT = 4'd5,
        S_MISS    = 4'd6,
        S_OVER    = 4'd7,
        S_CLEAR   = 4'd8,
        S_ERR     = 4'd9
    } state_t;

    localparam int DW = (HOLD > 1) ? $clog2(HOLD) : 1;

    state_t        r_state;
    state_t        w_next;
    logic          r_ready_d;
    logic          r_que_d;
    logic          r_ok_d;
    logic [DW-1:0] r_dwell;
    logic [DW-1:0] w_dwell_nxt;
    logic [3:0]    r_score;
    logic [3:0]    w_score_nxt;
    logic          r_ready_out;
    logic          w_ready_out_nxt;

    logic w_ready_rise;
    logic w_que_rise;
    logic w_ok_rise;
    logic w_hold_done;

    assign w_ready_rise = bus.READY_IN & ~r_ready_d;
    assign w_que_rise   = bus.QUE_IN   & ~r_que_d;
    assign w_ok_rise    = bus.OK_IN    & ~r_ok_d;
    assign w_hold_done  = (r_dwell == DW'(HOLD - 1));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_ready_d   <= 1'b0;
            r_que_d     <= 1'b0;
            r_ok_d      <= 1'b0;
            r_dwell     <= '0;
            r_score     <= 4'd0;
            r_ready_out <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_ready_d   <= bus.READY_IN;
            r_que_d     <= bus.QUE_IN;
            r_ok_d      <= bus.OK_IN;
            r_dwell     <= w_dwell_nxt;
            r_score     <= w_score_nxt;
            r_ready_out <= w_ready_out_nxt;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_ready_rise) w_next = S_READY;
            S_READY:   if (w_que_rise)   w_next = S_QGEN;
            S_QGEN:    if (bus.QUE)      w_next = S_INPUT;
            S_INPUT: begin
                // Invalid keypad entry wins over a simultaneous submit.
                if (bus.WRONG_IN)       w_next = S_ERR;
                else if (w_ok_rise)     w_next = S_JUDGE;
            end
            S_JUDGE: begin
                case (bus.JUDG_IN)
                    2'b01:   w_next = S_CORRECT;
                    2'b10:   w_next = S_MISS;
                    2'b11:   w_next = S_ERR;
                    default: w_next = S_JUDGE;
                endcase
            end
            S_CORRECT: if (w_hold_done)
                           w_next = (r_score == 4'(NUM_Q)) ? S_CLEAR : S_READY;
            S_MISS:    if (w_hold_done)
                           w_next = (bus.HP_IN == 2'd0) ? S_OVER : S_READY;
            S_ERR:     if (w_hold_done) w_next = S_INPUT;
            S_OVER,
            S_CLEAR:   if (w_ready_rise) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_dwell_nxt     = '0;
        w_score_nxt     = r_score;
        w_ready_out_nxt = (w_next == S_READY);
        if (w_next == r_state &&
            (r_state == S_CORRECT || r_state == S_MISS || r_state == S_ERR))
            w_dwell_nxt = r_dwell + 1'b1;
        if (r_state == S_IDLE)
            w_score_nxt = 4'd0;
        else if (w_next == S_CORRECT && r_state != S_CORRECT && r_score != 4'd15)
            w_score_nxt = r_score + 4'd1;
    end

    assign bus.STATE     = r_state;
    assign bus.READY_OUT = r_ready_out;
endmodule

// File: tb/tb_control.sv
// tb/tb_control.sv - directed and randomized checks of the quiz sequencer
module tb_control;
    localparam int NUM_Q = 2;
    localparam int HOLD  = 4;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    control_if bus ();

    control #(.NUM_Q(NUM_Q), .HOLD(HOLD)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Game model: remaining dwell cycles and a score, stepped once per edge
    int m_st;
    int m_left;
    int m_score;
    bit m_pr, m_pq, m_po;

    task automatic model_step();
        bit rr, qr, orr;
        rr = bus.READY_IN && !m_pr;
        qr = bus.QUE_IN   && !m_pq;
        orr = bus.OK_IN   && !m_po;
        if (!RST) begin
            m_st = 0; m_left = 0; m_score = 0;
            m_pr = 0; m_pq = 0; m_po = 0;
            return;
        end
        m_pr = bus.READY_IN; m_pq = bus.QUE_IN; m_po = bus.OK_IN;
        case (m_st)
            0: begin m_score = 0; if (rr) m_st = 1; end
            1: if (qr) m_st = 2;
            2: if (bus.QUE) m_st = 3;
            3: if (bus.WRONG_IN) begin m_st = 9; m_left = HOLD; end
               else if (orr) m_st = 4;
            4: case (bus.JUDG_IN)
                   2'd1: begin m_st = 5; m_left = HOLD;
                               if (m_score < 15) m_score++; end
                   2'd2: begin m_st = 6; m_left = HOLD; end
                   2'd3: begin m_st = 9; m_left = HOLD; end
                   default: ;
               endcase
            5: begin m_left--; if (m_left == 0) m_st = (m_score == NUM_Q) ? 8 : 1; end
            6: begin m_left--; if (m_left == 0) m_st = (bus.HP_IN == 0) ? 7 : 1; end
            9: begin m_left--; if (m_left == 0) m_st = 3; end
            7, 8: if (rr) m_st = 0;
            default: m_st = 0;
        endcase
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        check("model_state", {4'd0, bus.STATE}, 8'(m_st));
        check("model_ready_out", {7'd0, bus.READY_OUT}, {7'd0, (m_st == 1)});
    endtask

    task automatic press_ready(input logic [3:0] exp);
        bus.READY_IN = 1'b1; tick();
        check("ready_press", {4'd0, bus.STATE}, {4'd0, exp});
        bus.READY_IN = 1'b0; tick();
    endtask

    task automatic q_round(input logic [1:0] j, input logic [1:0] hp,
                           input logic [3:0] hold_st, input logic [3:0] after_st);
        bus.HP_IN = hp;
        bus.QUE_IN = 1'b1; tick(); check("qgen", {4'd0, bus.STATE}, 8'd2);
        bus.QUE_IN = 1'b0; bus.QUE = 1'b1; tick(); check("input", {4'd0, bus.STATE}, 8'd3);
        bus.QUE = 1'b0; bus.OK_IN = 1'b1; tick(); check("judge", {4'd0, bus.STATE}, 8'd4);
        bus.OK_IN = 1'b0; bus.JUDG_IN = j; tick();
        check("hold_entry", {4'd0, bus.STATE}, {4'd0, hold_st});
        bus.JUDG_IN = 2'd0;
        repeat (HOLD - 1) begin
            tick(); check("hold_dwell", {4'd0, bus.STATE}, {4'd0, hold_st});
        end
        tick(); check("hold_exit", {4'd0, bus.STATE}, {4'd0, after_st});
    endtask

    initial begin
        bus.READY_IN = 0; bus.QUE_IN = 0; bus.QUE = 0; bus.OK_IN = 0;
        bus.WRONG_IN = 0; bus.JUDG_IN = 0; bus.HP_IN = 0;
        m_st = 0; m_left = 0; m_score = 0; m_pr = 0; m_pq = 0; m_po = 0;

        for (int i = 0; i < 3; i++) begin
            bus.READY_IN = ~bus.READY_IN; bus.QUE_IN = ~bus.QUE_IN;
            bus.OK_IN = ~bus.OK_IN; bus.QUE = 1'b1; bus.JUDG_IN = 2'(i + 1);
            tick();
            check("rst_state", {4'd0, bus.STATE}, 8'd0);
            check("rst_ready_out", {7'd0, bus.READY_OUT}, 8'd0);
        end
        bus.READY_IN = 0; bus.QUE_IN = 0; bus.OK_IN = 0; bus.QUE = 0; bus.JUDG_IN = 0;
        tick();
        RST = 1'b1;
        tick();

        press_ready(4'd1);
        check("ready_out_high", {7'd0, bus.READY_OUT}, 8'd1);
        q_round(2'd1, 2'd3, 4'd5, 4'd1);
        q_round(2'd1, 2'd3, 4'd5, 4'd8);
        press_ready(4'd0);

        press_ready(4'd1);
        q_round(2'd2, 2'd2, 4'd6, 4'd1);
        q_round(2'd2, 2'd0, 4'd6, 4'd7);
        press_ready(4'd0);
        press_ready(4'd1);

        bus.QUE_IN = 1'b1; tick(); bus.QUE_IN = 1'b0;
        bus.QUE = 1'b1; tick(); bus.QUE = 1'b0;
        check("err_pre_input", {4'd0, bus.STATE}, 8'd3);
        bus.WRONG_IN = 1'b1; bus.OK_IN = 1'b1; tick();
        check("wrong_priority", {4'd0, bus.STATE}, 8'd9);
        bus.WRONG_IN = 1'b0; bus.OK_IN = 1'b0;
        repeat (HOLD - 1) begin tick(); check("err_dwell", {4'd0, bus.STATE}, 8'd9); end
        tick(); check("err_exit", {4'd0, bus.STATE}, 8'd3);

        bus.OK_IN = 1'b1;
        tick(); check("ok_held_first", {4'd0, bus.STATE}, 8'd4);
        repeat (19) begin tick(); check("ok_held", {4'd0, bus.STATE}, 8'd4); end
        bus.OK_IN = 1'b0;
        bus.JUDG_IN = 2'd3; tick(); check("judge_reserved", {4'd0, bus.STATE}, 8'd9);
        bus.JUDG_IN = 2'd0;
        repeat (HOLD) tick();
        check("err2_exit", {4'd0, bus.STATE}, 8'd3);

        bus.OK_IN = 1'b1; tick(); bus.OK_IN = 1'b0;
        bus.HP_IN = 2'd1; bus.JUDG_IN = 2'd2; tick();
        check("miss_entry", {4'd0, bus.STATE}, 8'd6);
        bus.JUDG_IN = 2'd0;
        tick();
        RST = 1'b0; tick();
        check("rst_mid_dwell", {4'd0, bus.STATE}, 8'd0);
        RST = 1'b1;
        tick();

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) bus.READY_IN = ~bus.READY_IN;
            if ($urandom_range(0, 2) == 0) bus.QUE_IN = ~bus.QUE_IN;
            if ($urandom_range(0, 2) == 0) bus.OK_IN = ~bus.OK_IN;
            bus.QUE      = ($urandom_range(0, 3) == 0);
            bus.WRONG_IN = ($urandom_range(0, 15) == 0);
            bus.JUDG_IN  = 2'($urandom_range(0, 3));
            bus.HP_IN    = 2'($urandom_range(0, 3));
            RST          = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/control.md
# control

Top-level game sequencer for the factorization quiz. It takes button, question-generator and judge-unit status signals and steps a 10-state machine through the game: title, ready, question, input, judge, result, game-over and clear. It publishes the current state code to the display/datapath blocks and asserts a ready flag when the next question may be requested.

## Interface
Parameters:
- NUM_Q, 8: correct answers needed to clear the game (1..15).
- HOLD, 4: dwell cycles in result/error states (>=1).

Ports (clock and reset first):
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset; synchronous and active-low.
- READY_IN  in  1  player start/continue button, level; rising edge used.
- QUE_IN  in  1  question request strobe, level; rising edge used.
- QUE  in  1  question generator done flag, level.
- OK_IN  in  1  answer submit button, level; rising edge used.
- WRONG_IN  in  1  invalid-entry flag from keypad, level.
- JUDG_IN  in  2  judge result: 00 pending, 01 correct, 10 incorrect, 11 reserved.
- HP_IN  in  2  remaining hit points, maintained externally.
- READY_OUT  out  1  registered; 1 only in READY state.
- STATE  out  4  registered current state code.

## Operation
- Edge detect: READY_IN, QUE_IN and OK_IN are each registered once. Rise = current & ~previous registered value.
- State codes:
  - IDLE=0
  - READY=1
  - QGEN=2
  - INPUT=3
  - JUDGE=4
  - CORRECT=5
  - MISS=6
  - OVER=7
  - CLEAR=8
  - ERR=9
  - Codes 10-15 are unreachable; if entered, go to IDLE next cycle.
- IDLE: READY_IN rise -> READY; clear correct counter.
- READY: QUE_IN rise -> QGEN.
- QGEN: QUE=1 -> INPUT.
- INPUT:
  - WRONG_IN=1 -> ERR.
  - Else OK_IN rise -> JUDGE.
  - WRONG_IN has priority when both occur in the same cycle.
- JUDGE:
  - 01 -> CORRECT.
  - 10 -> MISS.
  - 11 -> ERR.
  - 00 -> stay.
- CORRECT: on entry, correct counter +1 (4-bit). After HOLD cycles:
  - counter == NUM_Q -> CLEAR.
  - Else -> READY.
- MISS: after HOLD cycles, sample HP_IN:
  - HP_IN == 0 -> OVER.
  - Else -> READY.
- ERR: after HOLD cycles -> INPUT (same question).
- OVER, CLEAR: terminal; READY_IN rise -> IDLE.
- Dwell counter: zeroed on every state change. It counts up while in CORRECT, MISS or ERR; exit happens on the cycle it reads HOLD-1.
- Correct counter saturates at 15 and is cleared only in IDLE or by reset.
- Reset (RST=0 at a clock edge), from any state including mid-dwell:
  - STATE=0, READY_OUT=0.
  - Correct counter = 0, dwell counter = 0.
  - Edge registers = 0. A button already high when reset releases therefore produces a rise on the first cycle after release.

## Timing
- One transition per clock at most. STATE updates on the edge after the qualifying input is sampled.
- Rising-edge inputs: the level change is sampled at edge k and STATE changes at edge k (registered edge detect plus next-state in the same cycle). Buttons held high produce exactly one rise.
- READY_OUT is registered from the next state, so it is high in exactly the same cycles STATE=1.
- CORRECT, MISS and ERR each last exactly HOLD cycles.
- Inputs are assumed synchronous to CLK; no internal synchronizers.

## Test plan
- Reset: hold RST=0 for 3 cycles with all inputs toggling -> STATE=0 and READY_OUT=0 throughout.
- Happy path, NUM_Q=2, HOLD=4:
  - READY_IN rise -> STATE=1, READY_OUT=1.
  - QUE_IN rise -> 2; QUE=1 -> 3; OK_IN rise -> 4.
  - JUDG_IN=01 -> 5 for 4 cycles -> 1.
  - Repeat the loop -> 8.
  - READY_IN rise -> 0.
- Miss with HP_IN=2: JUDG_IN=10 -> 6 for 4 cycles -> 1.
- Miss with HP_IN=0: JUDG_IN=10 -> 6 for 4 cycles -> 7.
- Error: in INPUT, WRONG_IN=1 together with an OK_IN rise -> 9 (not 4), 4 cycles -> 3. JUDG_IN=11 in JUDGE -> 9.
- Held buttons: OK_IN held high 20 cycles in INPUT -> exactly one transition to 4. Reset asserted while in MISS mid-dwell -> STATE=0 next edge.
